// File: rtl/imem_loader.sv
// Purpose: streams a length header, payload and checksum into instruction memory as MSB-first byte writes.
// Latency: one cycle from payload byte acceptance to the registered byte write.
// Backpressure: ready_o depends only on state and start_i; stalls on valid_i change nothing.
module imem_loader #(
    parameter int unsigned RegBits  = 32,
    parameter int unsigned MemBytes = 32768,
    parameter int unsigned BaseAddr = 0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [7:0]         data_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic               we_o,
    output logic [RegBits-1:0] waddr_o,
    output logic [7:0]         wdata_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [1:0]         err_code_o
);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Largest word count that still fits between BaseAddr and the end of memory.
    localparam logic [33:0] MAX_WORDS = 34'((MemBytes - BaseAddr) / 4);

    state_t             state, state_nxt;
    logic [31:0]        count;
    logic [1:0]         len_idx;
    logic [RegBits-1:0] idx;
    logic [7:0]         sum;
    logic [1:0]         err_code_q, err_code_nxt;

    logic               accept;
    logic [31:0]        count_nxt;
    logic               last_byte;

    assign ready_o    = ((state == S_LEN) || (state == S_DATA) || (state == S_CSUM)) & ~start_i;
    assign accept     = valid_i & ready_o;
    assign count_nxt  = {count[23:0], data_i};
    // Byte index compared against 4*N at 34 bits so large counts cannot alias.
    assign last_byte  = (34'(idx) + 34'd1) == {count, 2'b00};

    assign busy_o     = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    assign done_o     = (state == S_DONE);
    assign err_o      = (state == S_ERR);
    assign err_code_o = err_code_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= S_LEN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and error cause; start_i overrides everything and re-arms for a header.
    always_comb begin
        state_nxt    = state;
        err_code_nxt = err_code_q;
        if (start_i) begin
            state_nxt    = S_LEN;
            err_code_nxt = 2'd0;
        end else if (accept) begin
            case (state)
                S_LEN: begin
                    if (len_idx == 2'd3) begin
                        if ({2'b00, count_nxt} > MAX_WORDS) begin
                            state_nxt    = S_ERR;
                            err_code_nxt = 2'd1;
                        end else if (count_nxt == 32'd0) begin
                            state_nxt = S_CSUM;
                        end else begin
                            state_nxt = S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (last_byte) begin
                        state_nxt = S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (data_i == sum) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt    = S_ERR;
                        err_code_nxt = 2'd2;
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Header shift, payload index/sum and the registered memory write port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count      <= '0;
            len_idx    <= '0;
            idx        <= '0;
            sum        <= '0;
            err_code_q <= '0;
            we_o       <= 1'b0;
            waddr_o    <= '0;
            wdata_o    <= '0;
        end else begin
            we_o       <= 1'b0;
            err_code_q <= err_code_nxt;
            if (start_i) begin
                count   <= '0;
                len_idx <= '0;
                idx     <= '0;
                sum     <= '0;
            end else if (accept) begin
                case (state)
                    S_LEN: begin
                        count   <= count_nxt;
                        len_idx <= len_idx + 2'd1;
                        if (len_idx == 2'd3) begin
                            idx <= '0;
                            sum <= '0;
                        end
                    end
                    S_DATA: begin
                        we_o    <= 1'b1;
                        waddr_o <= RegBits'(BaseAddr) + idx;
                        wdata_o <= data_i;
                        idx     <= idx + RegBits'(1);
                        sum     <= sum + data_i;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, valid;
    logic [7:0]  data;
    logic        sel;

    logic        ready0, we0, busy0, done0, err0;
    logic [31:0] waddr0;
    logic [7:0]  wdata0;
    logic [1:0]  code0;
    logic        ready1, we1, busy1, done1, err1;
    logic [31:0] waddr1;
    logic [7:0]  wdata1;
    logic [1:0]  code1;

    logic        ready_m, we_m, busy_m, done_m, err_m;
    logic [31:0] waddr_m;
    logic [7:0]  wdata_m;
    logic [1:0]  code_m;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  dat;
    } wr_t;

    wr_t         sb[$];
    wr_t         exp_wr;
    logic [7:0]  mem [0:1023];
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    imem_loader dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_i(data), .valid_i(valid),
        .ready_o(ready0), .we_o(we0), .waddr_o(waddr0), .wdata_o(wdata0),
        .busy_o(busy0), .done_o(done0), .err_o(err0), .err_code_o(code0)
    );

    imem_loader #(.BaseAddr(32'h100)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .data_i(data), .valid_i(valid),
        .ready_o(ready1), .we_o(we1), .waddr_o(waddr1), .wdata_o(wdata1),
        .busy_o(busy1), .done_o(done1), .err_o(err1), .err_code_o(code1)
    );

    assign ready_m = sel ? ready1 : ready0;
    assign we_m    = sel ? we1    : we0;
    assign waddr_m = sel ? waddr1 : waddr0;
    assign wdata_m = sel ? wdata1 : wdata0;
    assign busy_m  = sel ? busy1  : busy0;
    assign done_m  = sel ? done1  : done0;
    assign err_m   = sel ? err1   : err0;
    assign code_m  = sel ? code1  : code0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write the selected DUT presents is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && we_m) begin
                mem[waddr_m[9:0]] = wdata_m;
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", waddr_m, wdata_m);
                end else begin
                    exp_wr = sb.pop_front();
                    chk("wr_addr", waddr_m, exp_wr.addr);
                    chk("wr_data", {24'd0, wdata_m}, {24'd0, exp_wr.dat});
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        valid = 1'b1;
        data  = b;
        #1;
        chk("ready", {31'd0, ready_m}, 32'd1);
        @(posedge clk);
    endtask

    task automatic send_pay(input logic [7:0] b, input logic [31:0] addr);
        sb.push_back('{addr: addr, dat: b});
        send(b);
    endtask

    task automatic idle();
        @(negedge clk);
        valid = 1'b0;
        data  = 8'h00;
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
    endtask

    task automatic chk_status(input string tag, input logic d, input logic e, input logic [1:0] c, input logic b);
        chk({tag, "_done"}, {31'd0, done_m}, {31'd0, d});
        chk({tag, "_err"},  {31'd0, err_m},  {31'd0, e});
        chk({tag, "_code"}, {30'd0, code_m}, {30'd0, c});
        chk({tag, "_busy"}, {31'd0, busy_m}, {31'd0, b});
    endtask

    // Full stream: header, payload (expected writes pushed), checksum computed here.
    task automatic do_load(input logic [31:0] words[$], input bit bad, input bit gaps);
        logic [31:0] n, base, idx, w;
        logic [7:0]  s, b;
        base = sel ? 32'h100 : 32'h0;
        n    = words.size();
        idx  = 0;
        s    = 8'h00;
        send(n[31:24]); send(n[23:16]); send(n[15:8]); send(n[7:0]);
        foreach (words[i]) begin
            w = words[i];
            for (int k = 3; k >= 0; k--) begin
                b = w[8*k +: 8];
                if (gaps) repeat ($urandom_range(0, 2)) idle();
                send_pay(b, base + idx);
                s   = s + b;
                idx = idx + 1;
            end
        end
        send(bad ? (s ^ 8'h01) : s);
        idle();
    endtask

    logic [31:0] basic[$];
    logic [31:0] none[$];
    logic [31:0] big[$];
    logic [31:0] one[$];

    initial begin
        basic = '{32'h00500093, 32'h00100113};
        one   = '{32'h00500093};
        for (int i = 0; i < 16; i++) big.push_back(32'h00100093 + i * 32'h01020304);
        sel   = 1'b0;
        start = 1'b0;
        valid = 1'b0;
        data  = 8'h00;
        rst_n = 1'b0;
        #12;
        chk("rst_ready", {31'd0, ready_m}, 32'd1);
        chk("rst_we",    {31'd0, we_m},    32'd0);
        chk("rst_waddr", waddr_m,          32'd0);
        chk("rst_wdata", {24'd0, wdata_m}, 32'd0);
        chk_status("rst", 1'b0, 1'b0, 2'd0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic two-word load.
        do_load(basic, 1'b0, 1'b0);
        chk_status("basic", 1'b1, 1'b0, 2'd0, 1'b0);
        chk("basic_ready_idle", {31'd0, ready_m}, 32'd0);
        chk("basic_word0", {mem[0], mem[1], mem[2], mem[3]}, 32'h00500093);
        chk("basic_sb_empty", sb.size(), 32'd0);

        // Empty loads.
        pulse_start();
        chk_status("start_clear", 1'b0, 1'b0, 2'd0, 1'b1);
        do_load(none, 1'b0, 1'b0);
        chk_status("empty_ok", 1'b1, 1'b0, 2'd0, 1'b0);
        pulse_start();
        do_load(none, 1'b1, 1'b0);
        chk_status("empty_bad", 1'b0, 1'b1, 2'd2, 1'b0);

        // Length overflow boundary: 8193 words rejected, 8192 accepted.
        pulse_start();
        send(8'h00); send(8'h00); send(8'h20); send(8'h01);
        idle();
        chk_status("ovf", 1'b0, 1'b1, 2'd1, 1'b0);
        chk("ovf_ready", {31'd0, ready_m}, 32'd0);
        chk("ovf_no_writes", sb.size(), 32'd0);
        pulse_start();
        send(8'h00); send(8'h00); send(8'h20); send(8'h00);
        idle();
        chk_status("max_len", 1'b0, 1'b0, 2'd0, 1'b1);
        chk("max_len_ready", {31'd0, ready_m}, 32'd1);

        // 16-word load, gapless then with random stalls.
        pulse_start();
        do_load(big, 1'b0, 1'b0);
        chk_status("big", 1'b1, 1'b0, 2'd0, 1'b0);
        pulse_start();
        do_load(big, 1'b0, 1'b1);
        chk_status("big_gaps", 1'b1, 1'b0, 2'd0, 1'b0);
        chk("big_sb_empty", sb.size(), 32'd0);

        // Abort after 5 payload bytes on the BaseAddr=0x100 instance.
        sel = 1'b1;
        pulse_start();
        send(8'h00); send(8'h00); send(8'h00); send(8'h02);
        send_pay(8'h11, 32'h100); send_pay(8'h22, 32'h101); send_pay(8'h33, 32'h102);
        send_pay(8'h44, 32'h103); send_pay(8'h55, 32'h104);
        @(negedge clk);
        start = 1'b1;
        valid = 1'b1;
        data  = 8'hAA;
        #1;
        chk("abort_ready", {31'd0, ready_m}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        valid = 1'b0;
        #1;
        chk_status("abort", 1'b0, 1'b0, 2'd0, 1'b1);
        chk("abort_ready_after", {31'd0, ready_m}, 32'd1);
        chk("abort_sb_empty", sb.size(), 32'd0);
        do_load(one, 1'b0, 1'b0);
        chk_status("abort_reload", 1'b1, 1'b0, 2'd0, 1'b0);
        chk("reload_word", {mem[256], mem[257], mem[258], mem[259]}, 32'h00500093);

        // Asynchronous reset mid-DATA with a write pending.
        sel = 1'b0;
        pulse_start();
        send(8'h00); send(8'h00); send(8'h00); send(8'h02);
        send_pay(8'h00, 32'h0); send_pay(8'h50, 32'h1); send_pay(8'h00, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_we",    {31'd0, we_m},    32'd0);
        chk("arst_waddr", waddr_m,          32'd0);
        chk("arst_wdata", {24'd0, wdata_m}, 32'd0);
        chk("arst_ready", {31'd0, ready_m}, 32'd1);
        chk_status("arst", 1'b0, 1'b0, 2'd0, 1'b1);
        sb.delete();
        valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_load(basic, 1'b0, 1'b0);
        chk_status("post_rst", 1'b1, 1'b0, 2'd0, 1'b0);
        chk("final_sb_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
